// File: rtl/frame_stack_pkg.sv
// Shared types and default sizing for the frame_stack operand stack.
//   op_t     : operation code driven on frame_stack.op
//   status_t : result code reported on frame_stack.status
//   fsm_t    : sequencer states (IDLE, COPY, FINISH)
package frame_stack_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 7;
    localparam int DEF_FRAME_LOG = 4;
    localparam int DEF_PEEK      = 3;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        PUSH    = 4'd1,
        POP     = 4'd2,
        REPLACE = 4'd3,
        GET     = 4'd4,
        SET     = 4'd5,
        CALL    = 4'd6,
        RETURN  = 4'd7
    } op_t;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        EMPTY      = 3'd1,
        FULL       = 3'd2,
        UNDERFLOW  = 3'd3,
        OVERFLOW   = 3'd4,
        BAD_OFFSET = 3'd5,
        BAD_FRAME  = 3'd6
    } status_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        FINISH = 2'd2
    } fsm_t;

endpackage

// File: rtl/frame_stack_base_lifo.sv
// base_lifo: LIFO of saved frame bases for frame_stack.
//   clk, reset  : clock, synchronous active-high reset (empties the LIFO)
//   push        : store push_data on top (caller guarantees not full)
//   pop         : discard the top entry (caller guarantees not empty)
//   push_data   : base value to save
//   top         : most recently pushed entry (undefined when empty)
//   count       : number of entries held, 0..2**FRAME_LOG
module base_lifo
    import frame_stack_pkg::*;
#(
    parameter int FRAME_LOG = DEF_FRAME_LOG,
    parameter int W         = DEF_DEPTH + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       push_data,
    output logic [W-1:0]       top,
    output logic [FRAME_LOG:0] count
);

    localparam int FRAMES = 2 ** FRAME_LOG;
    localparam logic [FRAME_LOG:0]   ONE_CNT  = {{FRAME_LOG{1'b0}}, 1'b1};
    localparam logic [FRAME_LOG-1:0] ONE_ADDR = {{(FRAME_LOG-1){1'b0}}, 1'b1};

    logic [W-1:0]         mem [FRAMES];
    logic [FRAME_LOG:0]   count_reg;
    logic [FRAME_LOG-1:0] wr_addr;
    logic [FRAME_LOG-1:0] top_addr;

    // When the LIFO is full the low bits wrap to zero, so count-1 on the
    // low bits still lands on the last slot.
    assign wr_addr  = count_reg[FRAME_LOG-1:0];
    assign top_addr = count_reg[FRAME_LOG-1:0] - ONE_ADDR;
    assign top      = mem[top_addr];
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_addr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (push) begin
            count_reg <= count_reg + ONE_CNT;
        end else if (pop) begin
            count_reg <= count_reg - ONE_CNT;
        end
    end

endmodule

// File: rtl/frame_stack.sv
// frame_stack: operand stack with hardware call frames.
//   clk, reset   : clock, synchronous active-high reset
//   op_valid     : operation request; accepted when op_valid && op_ready
//   op_ready     : high only while the sequencer is IDLE
//   op, arg, data: operation code, count/offset operand, write value
//   index        : entries in use (absolute top)
//   base         : base of the current frame
//   frame_depth  : number of active nested frames
//   tos          : lane i = stack[index-1-i], zero when below base
//   get_data     : registered result of the last successful GET
//   status       : result code of the last accepted operation
// RETURN moves the result words down to the frame base one word per
// cycle, then restores the caller's base in a final FINISH cycle.
module frame_stack
    import frame_stack_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int FRAME_LOG = DEF_FRAME_LOG,
    parameter int PEEK      = DEF_PEEK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            op,
    input  logic [DEPTH:0]        arg,
    input  logic [WIDTH-1:0]      data,
    output logic [DEPTH:0]        index,
    output logic [DEPTH:0]        base,
    output logic [FRAME_LOG:0]    frame_depth,
    output logic [PEEK*WIDTH-1:0] tos,
    output logic [WIDTH-1:0]      get_data,
    output logic [2:0]            status
);

    localparam int MAX = 2 ** DEPTH;
    localparam logic [DEPTH:0]     MAX_IDX    = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0]     ONE_IDX    = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH-1:0]   ONE_ADDR   = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [FRAME_LOG:0] FRAMES_CNT = {1'b1, {FRAME_LOG{1'b0}}};

    // Architectural registers
    logic [DEPTH:0]   index_reg,    index_next;
    logic [DEPTH:0]   base_reg,     base_next;
    logic [WIDTH-1:0] get_data_reg, get_data_next;
    status_t          status_reg,   status_next;
    fsm_t             state_reg,    state_next;

    // RETURN copy cursors
    logic [DEPTH-1:0] src_reg, src_next;
    logic [DEPTH:0]   dst_reg, dst_next;
    logic [DEPTH:0]   cnt_reg, cnt_next;

    // Storage and its single write port
    logic [WIDTH-1:0] mem [MAX];
    logic             mem_we;
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    // Saved-base LIFO
    logic             lifo_push;
    logic             lifo_pop;
    logic [DEPTH:0]   lifo_top;
    logic [FRAME_LOG:0] lifo_count;

    // Operand-derived values
    logic [DEPTH:0]   room;        // entries in the current frame
    logic [DEPTH+1:0] off_sum;     // base+arg, one bit wider so it never wraps
    logic             offset_bad;
    logic [DEPTH-1:0] off_addr;
    logic [DEPTH-1:0] top_addr;
    logic [DEPTH:0]   new_base;

    base_lifo #(
        .FRAME_LOG (FRAME_LOG),
        .W         (DEPTH + 1)
    ) u_base_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .push_data (base_reg),
        .top       (lifo_top),
        .count     (lifo_count)
    );

    assign room       = index_reg - base_reg;
    assign off_sum    = {1'b0, base_reg} + {1'b0, arg};
    assign offset_bad = (off_sum >= {1'b0, index_reg});
    assign off_addr   = off_sum[DEPTH-1:0];
    assign top_addr   = index_reg[DEPTH-1:0] - ONE_ADDR;
    assign new_base   = index_reg - arg;

    assign op_ready    = (state_reg == IDLE);
    assign index       = index_reg;
    assign base        = base_reg;
    assign frame_depth = lifo_count;
    assign get_data    = get_data_reg;
    assign status      = status_reg;

    // Top-of-stack lanes; the visibility test uses the frame size so it
    // never depends on a subtraction that could wrap below zero.
    generate
        for (genvar gi = 0; gi < PEEK; gi++) begin : g_tos
            localparam logic [DEPTH:0]   LANE_I   = (DEPTH+1)'(gi);
            localparam logic [DEPTH-1:0] LANE_OFF = DEPTH'(gi + 1);
            logic [DEPTH-1:0] lane_addr;
            assign lane_addr = index_reg[DEPTH-1:0] - LANE_OFF;
            assign tos[gi*WIDTH +: WIDTH] = (room > LANE_I) ? mem[lane_addr] : '0;
        end
    endgenerate

    function automatic status_t ok_status(input logic [DEPTH:0] idx, input logic [DEPTH:0] b);
        if (idx == MAX_IDX) begin
            return FULL;
        end else if (idx == b) begin
            return EMPTY;
        end
        return NONE;
    endfunction

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        base_next     = base_reg;
        get_data_next = get_data_reg;
        status_next   = status_reg;
        src_next      = src_reg;
        dst_next      = dst_reg;
        cnt_next      = cnt_reg;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        lifo_push     = 1'b0;
        lifo_pop      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (op_valid) begin
                    case (op_t'(op))
                        PUSH: begin
                            if (index_reg == MAX_IDX) begin
                                status_next = OVERFLOW;
                            end else begin
                                mem_we      = 1'b1;
                                mem_addr    = index_reg[DEPTH-1:0];
                                mem_wdata   = data;
                                index_next  = index_reg + ONE_IDX;
                                status_next = ok_status(index_reg + ONE_IDX, base_reg);
                            end
                        end
                        POP: begin
                            if (arg > room) begin
                                status_next = UNDERFLOW;
                            end else begin
                                index_next  = index_reg - arg;
                                status_next = ok_status(index_reg - arg, base_reg);
                            end
                        end
                        REPLACE: begin
                            if (room == '0) begin
                                status_next = UNDERFLOW;
                            end else begin
                                mem_we      = 1'b1;
                                mem_addr    = top_addr;
                                mem_wdata   = data;
                                status_next = ok_status(index_reg, base_reg);
                            end
                        end
                        GET: begin
                            if (offset_bad) begin
                                status_next = BAD_OFFSET;
                            end else begin
                                get_data_next = mem[off_addr];
                                status_next   = ok_status(index_reg, base_reg);
                            end
                        end
                        SET: begin
                            if (offset_bad) begin
                                status_next = BAD_OFFSET;
                            end else begin
                                mem_we      = 1'b1;
                                mem_addr    = off_addr;
                                mem_wdata   = data;
                                status_next = ok_status(index_reg, base_reg);
                            end
                        end
                        CALL: begin
                            if (lifo_count == FRAMES_CNT) begin
                                status_next = OVERFLOW;
                            end else if (arg > room) begin
                                status_next = UNDERFLOW;
                            end else begin
                                lifo_push   = 1'b1;
                                base_next   = new_base;
                                status_next = ok_status(index_reg, new_base);
                            end
                        end
                        RETURN: begin
                            if (lifo_count == '0) begin
                                status_next = BAD_FRAME;
                            end else if (arg > room) begin
                                status_next = UNDERFLOW;
                            end else begin
                                // Results sit at the top of the frame; move
                                // them down to the frame base.
                                src_next   = index_reg[DEPTH-1:0] - arg[DEPTH-1:0];
                                dst_next   = base_reg;
                                cnt_next   = arg;
                                state_next = (arg == '0) ? FINISH : COPY;
                            end
                        end
                        default: begin
                            status_next = ok_status(index_reg, base_reg);
                        end
                    endcase
                end
            end
            COPY: begin
                // Copy runs upward with src >= dst, so overlapping ranges
                // are read before they are overwritten.
                mem_we    = 1'b1;
                mem_addr  = dst_reg[DEPTH-1:0];
                mem_wdata = mem[src_reg];
                src_next  = src_reg + ONE_ADDR;
                dst_next  = dst_reg + ONE_IDX;
                cnt_next  = cnt_reg - ONE_IDX;
                if (cnt_reg == ONE_IDX) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                // dst now points just past the last result word.
                index_next  = dst_reg;
                base_next   = lifo_top;
                lifo_pop    = 1'b1;
                status_next = ok_status(dst_reg, lifo_top);
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset edge must not disturb storage contents mid-operation.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_reg    <= '0;
            base_reg     <= '0;
            get_data_reg <= '0;
            status_reg   <= EMPTY;
            state_reg    <= IDLE;
            src_reg      <= '0;
            dst_reg      <= '0;
            cnt_reg      <= '0;
        end else begin
            index_reg    <= index_next;
            base_reg     <= base_next;
            get_data_reg <= get_data_next;
            status_reg   <= status_next;
            state_reg    <= state_next;
            src_reg      <= src_next;
            dst_reg      <= dst_next;
            cnt_reg      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_frame_stack.sv
// Self-checking bench for frame_stack: directed scenarios followed by a
// randomized run, all compared against a queue/array reference model.
module tb_frame_stack;
    import frame_stack_pkg::*;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 7;
    localparam int FRAME_LOG = 4;
    localparam int PEEK      = 3;
    localparam int MAX       = 128;
    localparam int FRAMES    = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  op_valid;
    logic                  op_ready;
    logic [3:0]            op;
    logic [DEPTH:0]        arg;
    logic [WIDTH-1:0]      data;
    logic [DEPTH:0]        index;
    logic [DEPTH:0]        base;
    logic [FRAME_LOG:0]    frame_depth;
    logic [PEEK*WIDTH-1:0] tos;
    logic [WIDTH-1:0]      get_data;
    logic [2:0]            status;

    always #5 clk = ~clk;

    frame_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .FRAME_LOG (FRAME_LOG),
        .PEEK      (PEEK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .arg         (arg),
        .data        (data),
        .index       (index),
        .base        (base),
        .frame_depth (frame_depth),
        .tos         (tos),
        .get_data    (get_data),
        .status      (status)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain array for storage, queue for saved bases.
    logic [WIDTH-1:0] m_mem [MAX];
    int               m_index;
    int               m_base;
    int               m_frames[$];
    logic [WIDTH-1:0] m_get;
    status_t          m_status;
    int               m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic status_t ok_st();
        if (m_index == MAX) return FULL;
        if (m_index == m_base) return EMPTY;
        return NONE;
    endfunction

    function automatic void model_reset();
        m_index = 0;
        m_base  = 0;
        m_frames.delete();
        m_get    = '0;
        m_status = EMPTY;
    endfunction

    function automatic void model_op(input op_t o, input int a, input logic [WIDTH-1:0] d);
        int room;
        room   = m_index - m_base;
        m_busy = 0;
        case (o)
            PUSH: if (m_index == MAX) m_status = OVERFLOW;
                  else begin m_mem[m_index] = d; m_index++; m_status = ok_st(); end
            POP: if (a > room) m_status = UNDERFLOW;
                 else begin m_index -= a; m_status = ok_st(); end
            REPLACE: if (room == 0) m_status = UNDERFLOW;
                     else begin m_mem[m_index-1] = d; m_status = ok_st(); end
            GET: if (a >= room) m_status = BAD_OFFSET;
                 else begin m_get = m_mem[m_base+a]; m_status = ok_st(); end
            SET: if (a >= room) m_status = BAD_OFFSET;
                 else begin m_mem[m_base+a] = d; m_status = ok_st(); end
            CALL: if (m_frames.size() == FRAMES) m_status = OVERFLOW;
                  else if (a > room) m_status = UNDERFLOW;
                  else begin m_frames.push_back(m_base); m_base = m_index - a; m_status = ok_st(); end
            RETURN: if (m_frames.size() == 0) m_status = BAD_FRAME;
                    else if (a > room) m_status = UNDERFLOW;
                    else begin
                        for (int k = 0; k < a; k++) m_mem[m_base+k] = m_mem[m_index-a+k];
                        m_index = m_base + a;
                        m_base  = m_frames.pop_back();
                        m_status = ok_st();
                        m_busy   = a + 1;
                    end
            default: m_status = ok_st();
        endcase
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".index"}, index, m_index);
        check({tag, ".base"}, base, m_base);
        check({tag, ".depth"}, frame_depth, m_frames.size());
        check({tag, ".status"}, status, m_status);
        check({tag, ".get"}, get_data, m_get);
        check({tag, ".ready"}, op_ready, 1);
        for (int i = 0; i < PEEK; i++) begin
            int pos;
            logic [WIDTH-1:0] exp;
            pos = m_index - 1 - i;
            exp = (pos >= m_base) ? m_mem[pos] : '0;
            check($sformatf("%s.tos%0d", tag, i), tos[i*WIDTH +: WIDTH], exp);
        end
        $display("op %s: index=%0d base=%0d depth=%0d status=%0d get=%0d",
                 tag, index, base, frame_depth, status, get_data);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_state(tag);
    endtask

    task automatic do_op(input op_t o, input int a, input logic [WIDTH-1:0] d, input string tag);
        int busy;
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        arg      = a[DEPTH:0];
        data     = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        model_op(o, a, d);
        busy = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && busy < 300) begin
            busy++;
            @(negedge clk);
        end
        check({tag, ".busy"}, busy, m_busy);
        check_state(tag);
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = '0;
        arg      = '0;
        data     = '0;
        for (int i = 0; i < MAX; i++) m_mem[i] = '0;

        // Reset state, then three pushes and a second reset
        do_reset("reset0");
        do_op(PUSH, 0, 10, "push10");
        do_op(PUSH, 0, 20, "push20");
        do_op(PUSH, 0, 30, "push30");
        do_reset("reset1");

        // Fill to capacity, overflow, drain in one POP
        for (int i = 0; i < MAX; i++) do_op(PUSH, 0, $urandom, "fill");
        do_op(PUSH, 0, 32'hdead, "push_full");
        do_op(POP, MAX, 0, "pop_all");

        // Frame entry, relative GET, offset bound
        for (int i = 1; i <= 5; i++) do_op(PUSH, 0, i, "push_seq");
        do_op(CALL, 2, 0, "call2");
        do_op(GET, 1, 0, "get1");
        do_op(GET, 2, 0, "get2_bad");
        do_op(PUSH, 0, 7, "push7");
        do_op(PUSH, 0, 8, "push8");
        do_op(RETURN, 2, 0, "return2");
        do_op(GET, 3, 0, "get3");
        do_op(GET, 4, 0, "get4");

        // Error boundaries
        do_op(RETURN, 0, 0, "return_noframe");
        for (int i = 0; i < FRAMES; i++) do_op(CALL, 0, 0, "call_nest");
        do_op(CALL, 0, 0, "call_overflow");
        do_op(POP, 1, 0, "pop_under");
        do_op(SET, 0, 0, "set_bad");
        do_op(REPLACE, 0, 0, "replace_under");
        for (int i = 0; i < FRAMES; i++) do_op(RETURN, 0, 0, "return_unnest");

        // Randomized run against the model
        do_reset("reset_rnd");
        for (int n = 0; n < 400; n++) begin
            op_t o;
            int  room;
            int  a;
            o    = op_t'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) o = PUSH;
            room = m_index - m_base;
            a    = $urandom_range(0, (room < 6) ? room + 1 : 6);
            if (o == POP && $urandom_range(0, 3) == 0) a = room + 1;
            do_op(o, a, $urandom, $sformatf("rnd%0d", n));
        end

        // Reset asserted during the second copy cycle of a RETURN
        do_reset("reset_abort");
        for (int i = 0; i < 6; i++) do_op(PUSH, 0, 100 + i, "push_abort");
        do_op(CALL, 5, 0, "call5");
        @(negedge clk);
        op_valid = 1'b1;
        op       = RETURN;
        arg      = 8'd4;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("abort.busy1", op_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("abort.ready", op_ready, 1);
        check("abort.index", index, 0);
        check("abort.status", status, EMPTY);
        check("abort.depth", frame_depth, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(PUSH, 0, 55, "push_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
